// File: rtl/snake_collision_detect.sv
// Two-snake collision and scoring judge.
// Evaluates next heads on refreshed; registers eaten flags and sticky result.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   clk_div    game-step tick level (synchronous to clk, informational)
//   refreshed  one-clk pulse, map_nxt valid for this step
//   dir1/dir2  snake directions
//   map        current map (heads + tiles)
//   map_nxt    next map (heads used for head-on cross-check)
//   mode       game mode, evaluation only in GAME
//   eaten1/2   snake k eats a point this step (held until next evaluation)
//   won/lost/draw  sticky result from player 1's point of view

package snake_pkg;

    localparam int MAP_W = 32;
    localparam int MAP_H = 24;
    localparam int XW    = 5;
    localparam int YW    = 5;

    typedef enum logic [1:0] {
        UP,
        DOWN,
        LEFT,
        RIGHT
    } dir_e;

    typedef enum logic [1:0] {
        MENU = 2'd0,
        GAME = 2'd1,
        OVER = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        EMPTY,
        SNAKE1,
        SNAKE2,
        POINT
    } tile_e;

    typedef struct packed {
        logic [XW-1:0] head1_x;
        logic [YW-1:0] head1_y;
        logic [XW-1:0] head2_x;
        logic [YW-1:0] head2_y;
        tile_e [MAP_W-1:0][MAP_H-1:0] tiles;
    } map_s;

endpackage

module snake_collision_detect
    import snake_pkg::*;
#(
    parameter int MAP_W = snake_pkg::MAP_W,
    parameter int MAP_H = snake_pkg::MAP_H
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clk_div,
    input  logic  refreshed,
    input  dir_e  dir1,
    input  dir_e  dir2,
    input  map_s  map,
    input  map_s  map_nxt,
    input  mode_e mode,
    output logic  eaten1,
    output logic  eaten2,
    output logic  won,
    output logic  lost,
    output logic  draw
);

    localparam logic [XW:0] LIM_X = (XW+1)'(MAP_W);
    localparam logic [YW:0] LIM_Y = (YW+1)'(MAP_H);
    localparam logic [XW:0] ONE_X = (XW+1)'(1);
    localparam logic [YW:0] ONE_Y = (YW+1)'(1);

    // The extra bit keeps off-grid moves visible: x-1 at 0 becomes
    // all-ones, x+1 at the edge reaches the limit; both fail the bound.
    function automatic logic [XW:0] nxt_x(
        input logic [XW-1:0] x,
        input dir_e          d
    );
        logic [XW:0] ex;
        ex = {1'b0, x};
        unique case (1'b1)
            (d == LEFT):  return ex - ONE_X;
            (d == RIGHT): return ex + ONE_X;
            default:      return ex;
        endcase
    endfunction

    function automatic logic [YW:0] nxt_y(
        input logic [YW-1:0] y,
        input dir_e          d
    );
        logic [YW:0] ey;
        ey = {1'b0, y};
        unique case (1'b1)
            (d == UP):   return ey - ONE_Y;
            (d == DOWN): return ey + ONE_Y;
            default:     return ey;
        endcase
    endfunction

    logic [XW:0] nx1, nx2;
    logic [YW:0] ny1, ny2;
    logic        off1, off2;
    tile_e       t1, t2;
    logic        body1, body2;
    logic        food1, food2;
    logic        swap, same, nxt_same;
    logic        headon, die1, die2;
    logic        latched;
    logic        e1_n, e2_n, won_n, lost_n, draw_n;
    logic        unused_ok;

    assign unused_ok = ^{clk_div, map_nxt.tiles};

    assign nx1 = nxt_x(map.head1_x, dir1);
    assign ny1 = nxt_y(map.head1_y, dir1);
    assign nx2 = nxt_x(map.head2_x, dir2);
    assign ny2 = nxt_y(map.head2_y, dir2);

    assign off1 = (nx1 >= LIM_X) || (ny1 >= LIM_Y);
    assign off2 = (nx2 >= LIM_X) || (ny2 >= LIM_Y);

    // Tile reads are only meaningful on-grid; they are gated by off*.
    assign t1 = map.tiles[nx1[XW-1:0]][ny1[YW-1:0]];
    assign t2 = map.tiles[nx2[XW-1:0]][ny2[YW-1:0]];

    assign body1 = !off1 && (t1 == SNAKE1 || t1 == SNAKE2);
    assign body2 = !off2 && (t2 == SNAKE1 || t2 == SNAKE2);
    assign food1 = !off1 && (t1 == POINT);
    assign food2 = !off2 && (t2 == POINT);

    assign same = (nx1 == nx2) && (ny1 == ny2);
    assign swap = (nx1 == {1'b0, map.head2_x})
               && (ny1 == {1'b0, map.head2_y})
               && (nx2 == {1'b0, map.head1_x})
               && (ny2 == {1'b0, map.head1_y});
    assign nxt_same = (map_nxt.head1_x == map_nxt.head2_x)
                   && (map_nxt.head1_y == map_nxt.head2_y);

    assign headon = same || swap || nxt_same;
    assign die1   = off1 || body1 || headon;
    assign die2   = off2 || body2 || headon;

    assign latched = won || lost || draw;

    always_comb begin
        e1_n   = eaten1;
        e2_n   = eaten2;
        won_n  = won;
        lost_n = lost;
        draw_n = draw;
        if (mode != GAME) begin
            e1_n   = 1'b0;
            e2_n   = 1'b0;
            won_n  = 1'b0;
            lost_n = 1'b0;
            draw_n = 1'b0;
        end else if (refreshed) begin
            if (latched) begin
                e1_n = 1'b0;
                e2_n = 1'b0;
            end else begin
                e1_n   = !die1 && food1;
                e2_n   = !die2 && food2;
                won_n  = die2 && !die1;
                lost_n = die1 && !die2;
                draw_n = die1 && die2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eaten1 <= 1'b0;
            eaten2 <= 1'b0;
            won    <= 1'b0;
            lost   <= 1'b0;
            draw   <= 1'b0;
        end else begin
            eaten1 <= e1_n;
            eaten2 <= e2_n;
            won    <= won_n;
            lost   <= lost_n;
            draw   <= draw_n;
        end
    end

endmodule

// File: tb/tb_snake_collision_detect.sv
// Directed bench for snake_collision_detect.
// Linear step sequence with immediate-assertion checks.

module tb_snake_collision_detect;
    import snake_pkg::*;

    logic  clk;
    logic  rst;
    logic  clk_div;
    logic  refreshed;
    dir_e  dir1;
    dir_e  dir2;
    map_s  m;
    map_s  mn;
    mode_e mode;
    logic  eaten1, eaten2, won, lost, draw;

    int checks;
    int failures;

    snake_collision_detect dut (
        .clk       (clk),
        .rst       (rst),
        .clk_div   (clk_div),
        .refreshed (refreshed),
        .dir1      (dir1),
        .dir2      (dir2),
        .map       (m),
        .map_nxt   (mn),
        .mode      (mode),
        .eaten1    (eaten1),
        .eaten2    (eaten2),
        .won       (won),
        .lost      (lost),
        .draw      (draw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic obs,
                       input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag,
                           input logic e1, input logic e2,
                           input logic w, input logic l,
                           input logic d);
        chk({tag, ".eaten1"}, eaten1, e1);
        chk({tag, ".eaten2"}, eaten2, e2);
        chk({tag, ".won"}, won, w);
        chk({tag, ".lost"}, lost, l);
        chk({tag, ".draw"}, draw, d);
    endtask

    task automatic step();
        @(negedge clk);
        refreshed = 1'b1;
        clk_div   = ~clk_div;
        @(posedge clk);
        #1 refreshed = 1'b0;
    endtask

    task automatic clear_maps();
        m  = '0;
        mn = '0;
        mn.head2_x = 5'd1;
        mn.head2_y = 5'd1;
    endtask

    task automatic new_game();
        @(negedge clk);
        mode = MENU;
        @(negedge clk);
        mode = GAME;
        clear_maps();
    endtask

    task automatic heads(input int x1, input int y1,
                         input int x2, input int y2,
                         input dir_e d1, input dir_e d2);
        m.head1_x = 5'(x1);
        m.head1_y = 5'(y1);
        m.head2_x = 5'(x2);
        m.head2_y = 5'(y2);
        m.tiles[x1][y1] = SNAKE1;
        m.tiles[x2][y2] = SNAKE2;
        dir1 = d1;
        dir2 = d2;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        clk_div   = 1'b0;
        refreshed = 1'b1;
        mode      = GAME;
        dir1      = UP;
        dir2      = LEFT;
        clear_maps();
        m.tiles[5][4] = POINT;
        heads(5, 5, 20, 5, UP, UP);

        // Reset held with active-looking inputs
        @(posedge clk);
        #1 chk_out("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        refreshed = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_out("idle", 0, 0, 0, 0, 0);

        // Free move
        new_game();
        heads(5, 5, 20, 5, UP, UP);
        step();
        chk_out("free", 0, 0, 0, 0, 0);

        // Eat by snake 1, held until next evaluation
        new_game();
        heads(5, 5, 20, 5, UP, UP);
        m.tiles[5][4] = POINT;
        step();
        chk_out("eat1", 1, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 chk("eat1_hold", eaten1, 1'b1);
        @(negedge clk);
        m.tiles[5][4] = SNAKE1;
        m.tiles[20][4] = SNAKE2;
        m.head1_y = 5'd4;
        m.head2_y = 5'd4;
        step();
        chk_out("eat1_next", 0, 0, 0, 0, 0);

        // Both eat in the same step
        new_game();
        heads(5, 5, 20, 5, UP, DOWN);
        m.tiles[5][4] = POINT;
        m.tiles[20][6] = POINT;
        step();
        chk_out("eat_both", 1, 1, 0, 0, 0);

        // Top wall for snake 1; result sticky; MENU clears
        new_game();
        heads(5, 0, 20, 5, UP, UP);
        m.tiles[20][4] = POINT;
        step();
        chk_out("wall_top", 0, 1, 0, 1, 0);
        step();
        chk_out("wall_sticky", 0, 0, 0, 1, 0);
        @(negedge clk);
        mode = MENU;
        @(posedge clk);
        #1 chk_out("menu_clr", 0, 0, 0, 0, 0);

        // No evaluation outside GAME
        heads(5, 0, 20, 5, UP, UP);
        step();
        chk_out("menu_noeval", 0, 0, 0, 0, 0);

        // Right wall for snake 1
        new_game();
        heads(31, 3, 20, 5, RIGHT, UP);
        step();
        chk_out("wall_right", 0, 0, 0, 1, 0);

        // Bottom wall for snake 2, left wall edge safe for 1
        new_game();
        heads(1, 3, 3, 23, LEFT, DOWN);
        step();
        chk_out("wall_bottom", 0, 0, 1, 0, 0);

        // Left wall for snake 2
        new_game();
        heads(6, 6, 0, 9, UP, LEFT);
        step();
        chk_out("wall_left", 0, 0, 1, 0, 0);

        // Head-on into the same cell, point there
        new_game();
        heads(10, 10, 12, 10, RIGHT, LEFT);
        m.tiles[11][10] = POINT;
        step();
        chk_out("headon", 0, 0, 0, 0, 1);

        // Heads swap cells
        new_game();
        heads(8, 8, 9, 8, RIGHT, LEFT);
        step();
        chk_out("swap", 0, 0, 0, 0, 1);

        // Snake 2 runs into snake 1 body
        new_game();
        heads(5, 5, 7, 5, UP, UP);
        m.tiles[7][4] = SNAKE1;
        step();
        chk_out("body_won", 0, 0, 1, 0, 0);

        // Async reset clears won between edges
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("async_rst", won, 1'b0);
        #1 rst = 1'b1;

        // Snake 1 into its own body
        new_game();
        heads(5, 5, 20, 5, DOWN, UP);
        m.tiles[5][6] = SNAKE1;
        step();
        chk_out("self_body", 0, 0, 0, 1, 0);

        // map_nxt heads coincide: draw despite distinct computed heads
        new_game();
        heads(5, 5, 20, 5, UP, UP);
        mn.head1_x = 5'd9;
        mn.head1_y = 5'd9;
        mn.head2_x = 5'd9;
        mn.head2_y = 5'd9;
        step();
        chk_out("nxt_draw", 0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
